// File: rtl/branch_predict_ctrl_if.sv
// rtl/branch_predict_ctrl_if.sv - redirect/flush channel between predictor and front end
interface branch_predict_ctrl_if #(
    parameter int XLEN = 32
);
    logic            o_redirect_valid;
    logic [XLEN-1:0] o_redirect_pc;
    logic            i_redirect_ready;
    logic            o_flush;

    modport master (
        output o_redirect_valid,
        output o_redirect_pc,
        output o_flush,
        input  i_redirect_ready
    );

    modport slave (
        input  o_redirect_valid,
        input  o_redirect_pc,
        input  o_flush,
        output i_redirect_ready
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - 2-bit counter direction predictor with mispredict redirect FSM
module branch_predict_ctrl #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [XLEN-1:0]             i_f_pc,
    output logic                        o_f_pred_take,
    input  logic                        i_ex_valid,
    input  logic [XLEN-1:0]             i_ex_pc,
    input  logic                        i_ex_pred_take,
    input  logic                        i_ex_take,
    input  logic [XLEN-1:0]             i_ex_target,
    branch_predict_ctrl_if.master       rd,
    output logic [31:0]                 o_br_count,
    output logic [31:0]                 o_mp_count
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic {IDLE, PEND} state_t;

    state_t           state;
    logic [1:0]       cnt_tbl [ENTRIES];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             unused_pc_bits;

    assign f_idx          = i_f_pc[IDX_W+1:2];
    assign ex_idx         = i_ex_pc[IDX_W+1:2];
    assign o_f_pred_take  = cnt_tbl[f_idx][1];
    assign unused_pc_bits = ^{i_f_pc[XLEN-1:IDX_W+2], i_f_pc[1:0], i_ex_pc[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_tbl[i] <= 2'b01;
            end
            state               <= IDLE;
            rd.o_redirect_valid <= 1'b0;
            rd.o_redirect_pc    <= '0;
            rd.o_flush          <= 1'b0;
            o_br_count          <= '0;
            o_mp_count          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd.o_flush <= 1'b0;
                    if (i_ex_valid) begin
                        if (i_ex_take) begin
                            if (cnt_tbl[ex_idx] != 2'b11) cnt_tbl[ex_idx] <= cnt_tbl[ex_idx] + 2'b01;
                        end else begin
                            if (cnt_tbl[ex_idx] != 2'b00) cnt_tbl[ex_idx] <= cnt_tbl[ex_idx] - 2'b01;
                        end
                        if (o_br_count != 32'hFFFF_FFFF) o_br_count <= o_br_count + 32'd1;
                        if (i_ex_take != i_ex_pred_take) begin
                            if (o_mp_count != 32'hFFFF_FFFF) o_mp_count <= o_mp_count + 32'd1;
                            rd.o_redirect_pc    <= i_ex_take ? i_ex_target : i_ex_pc + XLEN'(4);
                            rd.o_redirect_valid <= 1'b1;
                            rd.o_flush          <= 1'b1;
                            state               <= PEND;
                        end
                    end
                end
                PEND: begin
                    // Flush is raised on PEND entry only; any ex_valid here is wrong-path.
                    rd.o_flush <= 1'b0;
                    if (rd.i_redirect_ready) begin
                        rd.o_redirect_valid <= 1'b0;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Direction predictor and misprediction controller wrapped around the branch unit (bu).
- Holds a direct-mapped table of 2-bit saturating counters. Fetch reads it combinationally for a taken/not-taken guess.
- At execute, compares the guess with bu o_take, trains the table and issues a held redirect/flush request to the front end.
- Also counts resolved branches and mispredictions for performance monitoring.

Parameters:
- XLEN, 32, datapath width (matches cotm32_pkg XLEN).
- ENTRIES, 16, number of counters; power of two, 2..256.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_f_pc  in  XLEN  fetch PC to predict.
- o_f_pred_take  out  1  predicted direction for i_f_pc (combinational).
- i_ex_valid  in  1  execute stage holds a valid branch this cycle.
- i_ex_pc  in  XLEN  PC of the resolving branch.
- i_ex_pred_take  in  1  prediction carried down the pipe with that branch.
- i_ex_take  in  1  actual outcome, from bu o_take.
- i_ex_target  in  XLEN  taken target, pc+imm.
- o_redirect_valid  out  1  redirect request to fetch.
- o_redirect_pc  out  XLEN  correct next PC.
- i_redirect_ready  in  1  fetch accepts the redirect.
- o_flush  out  1  one-cycle pulse to kill younger instructions.
- o_br_count  out  32  resolved-branch counter.
- o_mp_count  out  32  mispredict counter.

Behaviour:
- Index is pc[IDX_W+1:2]. Bits [1:0] are ignored.
- Counter encoding:
  - 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - o_f_pred_take is bit 1 of table[idx(i_f_pc)].
- Reset (i_rst high at a clock edge):
  - every table entry becomes 01.
  - o_redirect_valid = 0, o_redirect_pc = 0, o_flush = 0.
  - both counters = 0.
  - FSM goes to IDLE.
  - A pending redirect is discarded.
- FSM states: IDLE and PEND.
- IDLE, on a clock edge with i_ex_valid = 1 (the resolution is "accepted"):
  - Table update: table[idx(i_ex_pc)] increments, saturating at 11, if i_ex_take = 1; otherwise it decrements, saturating at 00.
  - o_br_count increments, saturating at 32'hFFFF_FFFF.
  - If i_ex_take != i_ex_pred_take, this is a mispredict:
    - o_mp_count increments, saturating.
    - o_redirect_pc = i_ex_take ? i_ex_target : i_ex_pc + 4, with wrap modulo 2^XLEN.
    - o_redirect_valid = 1 and o_flush = 1, both registered, so visible 1 cycle after the resolving cycle.
    - Go to PEND.
  - Otherwise stay in IDLE with no redirect.
- PEND:
  - o_redirect_valid and o_redirect_pc are held stable until a cycle where i_redirect_ready = 1.
  - At that cycle's edge, o_redirect_valid drops and the FSM returns to IDLE.
  - o_flush is high only in the first PEND cycle, regardless of ready.
  - All i_ex_valid during PEND are treated as wrong-path: no table update, no counter change, no new redirect.
  - An i_ex_valid in the same cycle as the ready handshake is also ignored.
- Same-index read and write in one cycle: o_f_pred_take shows the pre-update value; there is no bypass. The new value is visible the following cycle.
- o_f_pred_take is a pure function of the table and i_f_pc. It is valid during PEND and in the cycle after reset.
- No X propagation: every registered output has a defined reset value.

Test Plan:
- Reset, then sweep i_f_pc = 0x00, 0x04 .. 0x3C -> o_f_pred_take = 0 for all 16 entries (counter 01). o_redirect_valid = 0, both counts = 0.
- Mispredict not-taken→taken:
  - Stimulus: i_ex_valid = 1, pc = 0x100, pred = 0, take = 1, target = 0x200, i_redirect_ready = 0.
  - Next cycle: o_redirect_valid = 1, o_redirect_pc = 0x200, o_flush = 1.
  - Cycle after: o_flush = 0, valid held.
  - Raise ready -> valid = 0 next cycle.
  - o_mp_count = 1, o_br_count = 1.
  - Entry for 0x100 = 10, so i_f_pc = 0x100 gives pred = 1.
- Mispredict taken→not-taken: pc = 0xFFFF_FFFC, pred = 1, take = 0 -> o_redirect_pc = 0x0000_0000 (wrap).
- Correct prediction: pc = 0x40, pred = 0, take = 0 -> no redirect, no flush, o_br_count += 1, o_mp_count unchanged, entry saturates 01→00→00 over two resolutions.
- Wrong-path filtering:
  - Hold PEND with ready = 0.
  - Drive 3 i_ex_valid mispredicts during PEND, one of them in the ready cycle.
  - Required: counts unchanged, table unchanged, o_redirect_pc unchanged.
- Mid-operation reset and aliasing:
  - Assert i_rst during PEND -> next cycle o_redirect_valid = 0, table back to 01.
  - Train pc = 0x00 taken twice -> pc = 0x40 (same index, ENTRIES = 16) predicts 1.
  - Same-cycle fetch of 0x00 during the first training resolution shows the old value 0.
